// File: rtl/mod_n_counter.sv
// Purpose : free-running modulo-n up/down counter, wraps at 0 and n-1 in both directions.
// Latency : one clock; count (and tc) are registered, with no combinational path from inputs.
// Backpressure: none; one step every clock edge and there is no enable or stall.
//
// Ports:
//   clk      rising-edge clock (single domain)
//   rst      synchronous active-high reset, forces count (and tc) to 0
//   up_down  1 = count up, 0 = count down, sampled at the clock edge
//   count    registered counter value, range 0..n-1
//   tc       (only with MODENCOUNTER_TC_EN) registered terminal-count flag aligned with count
//
// Optional feature macro: MODENCOUNTER_TC_EN (adds the tc output).
module mod_n_counter #(
  parameter int n     = 16,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_down,
  output logic [WIDTH-1:0] count
`ifdef MODENCOUNTER_TC_EN
  ,
  output logic             tc
`endif
);

  // Reject illegal configurations before anything is built.
  if (n < 2 || n > (2 ** WIDTH)) begin : g_bad_param
    $error("mod_n_counter: n=%0d must lie in 2..2**WIDTH (WIDTH=%0d)", n, WIDTH);
  end

  // Highest legal value, truncated to WIDTH bits so n = 2**WIDTH needs no extra bit.
  localparam logic [WIDTH-1:0] LAST = WIDTH'(n - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_next;

  // Next-state arithmetic. A value above LAST can only appear through forcing or
  // X-recovery; it returns to 0 regardless of direction.
  always_comb begin
    count_next = count;
    if (count > LAST) begin
      count_next = '0;
    end else if (up_down) begin
      count_next = (count == LAST) ? '0 : count + ONE;
    end else begin
      count_next = (count == '0) ? LAST : count - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

`ifdef MODENCOUNTER_TC_EN
  logic [WIDTH-1:0] terminal;

  // Terminal value depends on the direction sampled on the same edge that loads
  // count_next, so the registered flag lines up with the registered count.
  always_comb begin
    terminal = up_down ? LAST : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tc <= 1'b0;
    end else begin
      tc <= (count_next == terminal);
    end
  end
`endif

endmodule

// File: tb/tb_mod_n_counter.sv
module tb_mod_n_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up_down = 1'b1;
  logic [3:0] count16;
  logic [3:0] count10;
`ifdef MODENCOUNTER_TC_EN
  logic       tc16;
  logic       tc10;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: plain modular arithmetic on integers.
  int m16 = 0;
  int m10 = 0;
  bit t16 = 1'b0;
  bit t10 = 1'b0;
  bit model_ok = 1'b0;

  always #5 clk = ~clk;

  mod_n_counter #(.n(16), .WIDTH(4)) dut16 (
    .clk     (clk),
    .rst     (rst),
    .up_down (up_down),
    .count   (count16)
`ifdef MODENCOUNTER_TC_EN
    ,
    .tc      (tc16)
`endif
  );

  mod_n_counter #(.n(10), .WIDTH(4)) dut10 (
    .clk     (clk),
    .rst     (rst),
    .up_down (up_down),
    .count   (count10)
`ifdef MODENCOUNTER_TC_EN
    ,
    .tc      (tc10)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Model update on every rising edge using the inputs as the DUT sees them.
  always @(posedge clk) begin
    if (rst) begin
      m16 = 0;
      m10 = 0;
      t16 = 1'b0;
      t10 = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (up_down) begin
        m16 = (m16 + 1) % 16;
        m10 = (m10 + 1) % 10;
      end else begin
        m16 = (m16 + 15) % 16;
        m10 = (m10 + 9) % 10;
      end
      t16 = (m16 == (up_down ? 15 : 0));
      t10 = (m10 == (up_down ? 9 : 0));
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      check("count16_model", int'(count16), m16);
      check("count10_model", int'(count10), m10);
`ifdef MODENCOUNTER_TC_EN
      check("tc16_model", int'(tc16), int'(t16));
      check("tc10_model", int'(tc10), int'(t10));
`endif
    end
  end

  // Apply inputs, then let one rising edge consume them; returns 1 ns after the edge.
  task automatic step(input bit r, input bit ud);
    rst = r;
    up_down = ud;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for three edges with up_down high.
    step(1'b1, 1'b1);
    check("reset_first_edge16", int'(count16), 0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("reset_hold16", int'(count16), 0);
    check("reset_hold10", int'(count10), 0);
`ifdef MODENCOUNTER_TC_EN
    check("reset_tc10", int'(tc10), 0);
    check("reset_tc16", int'(tc16), 0);
`endif

    // Up count, 20 edges: 1..15, 0, 1..4 on mod-16.
    step(1'b0, 1'b1);
    check("up_first16", int'(count16), 1);
    for (int i = 2; i <= 20; i++) begin
      step(1'b0, 1'b1);
      if (i == 9) begin
        check("up_nine10", int'(count10), 9);
`ifdef MODENCOUNTER_TC_EN
        check("up_tc_at9_10", int'(tc10), 1);
`endif
      end
      if (i == 10) begin
        check("up_wrap10", int'(count10), 0);
`ifdef MODENCOUNTER_TC_EN
        check("up_tc_after_wrap10", int'(tc10), 0);
`endif
      end
      if (i == 15) begin
        check("up_top16", int'(count16), 15);
`ifdef MODENCOUNTER_TC_EN
        check("up_tc_at15_16", int'(tc16), 1);
`endif
      end
      if (i == 16) check("up_wrap16", int'(count16), 0);
    end
    check("up_end16", int'(count16), 4);
    check("up_end10", int'(count10), 0);

    // Down count, 20 edges from 4: 3,2,1,0,15,... ends at 0.
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b0);
      if (i == 4) begin
        check("down_zero16", int'(count16), 0);
`ifdef MODENCOUNTER_TC_EN
        check("down_tc_at0_16", int'(tc16), 1);
`endif
      end
      if (i == 5) check("down_wrap16", int'(count16), 15);
      if (i == 1) check("down_wrap10", int'(count10), 9);
    end
    check("down_end16", int'(count16), 0);

    // Direction change around 7: 6,5 then back up 6,7.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
    check("dir_at7", int'(count16), 7);
    step(1'b0, 1'b0);
    check("dir_down6", int'(count16), 6);
    step(1'b0, 1'b0);
    check("dir_down5", int'(count16), 5);
    step(1'b0, 1'b1);
    check("dir_up6", int'(count16), 6);
    step(1'b0, 1'b1);
    check("dir_up7", int'(count16), 7);

    // Count down from 7 to 11, then reset mid-count.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
    check("pre_reset11", int'(count16), 11);
    step(1'b1, 1'b0);
    check("mid_reset16", int'(count16), 0);
    check("mid_reset10", int'(count10), 0);
    step(1'b0, 1'b0);
    check("post_reset_down16", int'(count16), 15);
    check("post_reset_down10", int'(count10), 9);
`ifdef MODENCOUNTER_TC_EN
    check("post_reset_tc10", int'(tc10), 0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0);
    check("down_to0_10", int'(count10), 0);
    check("down_tc_at0_10", int'(tc10), 1);
`endif

    // Randomized directions with occasional resets, checked by the model each cycle.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1);
    end
    step(1'b0, 1'b1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
